// File: rtl/pipe_hazard_unit.sv
// rtl/pipe_hazard_unit.sv - load-use scoreboard, operand forwarding and flush control for an in-order pipeline
// Purpose : decides when ID must stall behind an in-flight load, when IF/ID is flushed on a taken
//           branch, which EX operand source to select, and when ID reads the WB result directly.
// Ports   : clk, rst (sync, active-high)
//           id_*   - instruction in decode: sources and which of them are really read
//           ex_*   - instruction in execute: sources, destination, regwrite/load flags
//           mem_*/wb_* - destinations of the two later stages
//           branch_taken - redirect resolved in EX
//           stall, flush_ifid, bubble_idex, fwd_a/fwd_b (00 ID/EX, 10 EX/MEM, 01 MEM/WB),
//           id_byp_a/id_byp_b, stall_cnt/flush_cnt/fwd_cnt (saturating)
// Config  : PIPE_HAZARD_PERF_CNT_EN defined builds the performance counters; otherwise they read 0.
module pipe_hazard_unit #(
    parameter int NREG    = 32,
    parameter int MEM_LAT = 1,
    parameter int CNT_W   = 16,
    localparam int REGW   = $clog2(NREG)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [REGW-1:0]  id_rs,
    input  logic [REGW-1:0]  id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic             ex_valid,
    input  logic [REGW-1:0]  ex_rs,
    input  logic [REGW-1:0]  ex_rt,
    input  logic [REGW-1:0]  ex_wreg,
    input  logic             ex_regwrite,
    input  logic             ex_is_load,
    input  logic [REGW-1:0]  mem_wreg,
    input  logic             mem_regwrite,
    input  logic [REGW-1:0]  wb_wreg,
    input  logic             wb_regwrite,
    input  logic             branch_taken,
    output logic             stall,
    output logic             flush_ifid,
    output logic             bubble_idex,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             id_byp_a,
    output logic             id_byp_b,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [CNT_W-1:0] fwd_cnt
);

    localparam logic [2:0] LOAD_INIT = 3'(MEM_LAT - 1);

    // Countdown of remaining load-latency cycles per register; entry 0 never holds a value.
    logic [2:0] sb_q [NREG];
    logic [2:0] sb_d [NREG];

    logic ex_load;
    logic load_issue;
    logic busy_a;
    logic busy_b;

    assign ex_load    = ex_valid & ex_is_load & ex_regwrite & (ex_wreg != '0);
    // A load squashed by the branch in EX never reaches memory, so it must not be tracked.
    assign load_issue = ex_load & ~branch_taken;

    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            sb_d[r] = (sb_q[r] != 3'd0) ? sb_q[r] - 3'd1 : 3'd0;
            if (load_issue && ex_wreg == REGW'(r)) begin
                sb_d[r] = LOAD_INIT;
            end
        end
        sb_d[0] = 3'd0;
    end

    always_ff @(posedge clk) begin
        for (int r = 0; r < NREG; r++) begin
            if (rst) begin
                sb_q[r] <= 3'd0;
            end else begin
                sb_q[r] <= sb_d[r];
            end
        end
    end

    // A source is busy while its load sits in EX (value not yet read from memory)
    // or while its scoreboard entry is still counting down.
    always_comb begin
        busy_a = id_valid & id_use_rs & (id_rs != '0) &
                 ((ex_load & (id_rs == ex_wreg)) | (sb_q[id_rs] != 3'd0));
        busy_b = id_valid & id_use_rt & (id_rt != '0) &
                 ((ex_load & (id_rt == ex_wreg)) | (sb_q[id_rt] != 3'd0));
        // The redirect discards the stalled instruction anyway, so flush wins.
        stall       = (busy_a | busy_b) & ~branch_taken;
        flush_ifid  = branch_taken;
        bubble_idex = stall | branch_taken;
    end

    // EX/MEM is checked first: it holds the younger write to the same register.
    always_comb begin
        fwd_a = 2'b00;
        if (mem_regwrite && mem_wreg != '0 && mem_wreg == ex_rs) begin
            fwd_a = 2'b10;
        end else if (wb_regwrite && wb_wreg != '0 && wb_wreg == ex_rs) begin
            fwd_a = 2'b01;
        end
        fwd_b = 2'b00;
        if (mem_regwrite && mem_wreg != '0 && mem_wreg == ex_rt) begin
            fwd_b = 2'b10;
        end else if (wb_regwrite && wb_wreg != '0 && wb_wreg == ex_rt) begin
            fwd_b = 2'b01;
        end
        id_byp_a = wb_regwrite & (wb_wreg != '0) & (wb_wreg == id_rs);
        id_byp_b = wb_regwrite & (wb_wreg != '0) & (wb_wreg == id_rt);
    end

`ifdef PIPE_HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic [CNT_W-1:0] fwd_cnt_q,   fwd_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        fwd_cnt_d   = fwd_cnt_q;
        if (stall && !(&stall_cnt_q)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (branch_taken && !(&flush_cnt_q)) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
        if ((fwd_a != 2'b00 || fwd_b != 2'b00) && !(&fwd_cnt_q)) begin
            fwd_cnt_d = fwd_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
            fwd_cnt_q   <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            fwd_cnt_q   <= fwd_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
    assign fwd_cnt   = fwd_cnt_q;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
    assign fwd_cnt   = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// tb/tb_pipe_hazard_unit.sv - self-checking bench: MEM_LAT=1/CNT_W=16 and MEM_LAT=3/CNT_W=4 instances on shared inputs
module tb_pipe_hazard_unit;
    localparam int NREG = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       id_valid, id_use_rs, id_use_rt;
    logic [4:0] id_rs, id_rt;
    logic       ex_valid, ex_regwrite, ex_is_load;
    logic [4:0] ex_rs, ex_rt, ex_wreg;
    logic [4:0] mem_wreg, wb_wreg;
    logic       mem_regwrite, wb_regwrite, branch_taken;

    logic       stall_o [2];
    logic       flush_o [2];
    logic       bubble_o[2];
    logic       byp_a_o [2];
    logic       byp_b_o [2];
    logic [1:0] fwd_a_o [2];
    logic [1:0] fwd_b_o [2];
    logic [15:0] c1_stall, c1_flush, c1_fwd;
    logic [3:0]  c3_stall, c3_flush, c3_fwd;

    pipe_hazard_unit #(.NREG(NREG), .MEM_LAT(1), .CNT_W(16)) u_l1 (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
        .ex_valid(ex_valid), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_wreg(ex_wreg),
        .ex_regwrite(ex_regwrite), .ex_is_load(ex_is_load),
        .mem_wreg(mem_wreg), .mem_regwrite(mem_regwrite), .wb_wreg(wb_wreg), .wb_regwrite(wb_regwrite),
        .branch_taken(branch_taken),
        .stall(stall_o[0]), .flush_ifid(flush_o[0]), .bubble_idex(bubble_o[0]),
        .fwd_a(fwd_a_o[0]), .fwd_b(fwd_b_o[0]), .id_byp_a(byp_a_o[0]), .id_byp_b(byp_b_o[0]),
        .stall_cnt(c1_stall), .flush_cnt(c1_flush), .fwd_cnt(c1_fwd)
    );

    pipe_hazard_unit #(.NREG(NREG), .MEM_LAT(3), .CNT_W(4)) u_l3 (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
        .ex_valid(ex_valid), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_wreg(ex_wreg),
        .ex_regwrite(ex_regwrite), .ex_is_load(ex_is_load),
        .mem_wreg(mem_wreg), .mem_regwrite(mem_regwrite), .wb_wreg(wb_wreg), .wb_regwrite(wb_regwrite),
        .branch_taken(branch_taken),
        .stall(stall_o[1]), .flush_ifid(flush_o[1]), .bubble_idex(bubble_o[1]),
        .fwd_a(fwd_a_o[1]), .fwd_b(fwd_b_o[1]), .id_byp_a(byp_a_o[1]), .id_byp_b(byp_b_o[1]),
        .stall_cnt(c3_stall), .flush_cnt(c3_flush), .fwd_cnt(c3_fwd)
    );

    // Reference model: a loaded register is unavailable to ID until cycle avail[i][r].
    int lat [2] = '{1, 3};
    int cmax[2] = '{65535, 15};
    int avail[2][NREG];
    int m_scnt[2], m_fcnt[2], m_wcnt[2];
    int cyc;
    int n_pass, n_total;

    task automatic chk(input string nm, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    endtask

    function automatic int exp_cnt(input int v);
`ifdef PIPE_HAZARD_PERF_CNT_EN
        return v;
`else
        return 0 * v;
`endif
    endfunction

    function automatic logic ld_in_ex();
        return ex_valid && ex_is_load && ex_regwrite && ex_wreg != 0;
    endfunction

    function automatic logic src_busy(input int i, input logic use_src, input logic [4:0] r);
        return id_valid && use_src && r != 0 && ((ld_in_ex() && r == ex_wreg) || cyc < avail[i][r]);
    endfunction

    function automatic logic m_stall(input int i);
        return !branch_taken && (src_busy(i, id_use_rs, id_rs) || src_busy(i, id_use_rt, id_rt));
    endfunction

    function automatic int m_fwd(input logic [4:0] s);
        if (mem_regwrite && mem_wreg != 0 && mem_wreg == s) return 2;
        if (wb_regwrite && wb_wreg != 0 && wb_wreg == s) return 1;
        return 0;
    endfunction

    function automatic int sat(input int v, input int mx);
        return (v + 1 > mx) ? mx : v + 1;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 2; i++) begin
            for (int r = 0; r < NREG; r++) avail[i][r] = 0;
            m_scnt[i] = 0; m_fcnt[i] = 0; m_wcnt[i] = 0;
        end
    endtask

    // Compare both instances with the model mid-cycle, then advance the model past the coming edge.
    task automatic eval();
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            int fa, fb, st;
            st = m_stall(i); fa = m_fwd(ex_rs); fb = m_fwd(ex_rt);
            chk($sformatf("stall[%0d]", i), stall_o[i], st);
            chk($sformatf("flush[%0d]", i), flush_o[i], branch_taken);
            chk($sformatf("bubble[%0d]", i), bubble_o[i], st | branch_taken);
            chk($sformatf("fwd_a[%0d]", i), fwd_a_o[i], fa);
            chk($sformatf("fwd_b[%0d]", i), fwd_b_o[i], fb);
            chk($sformatf("byp_a[%0d]", i), byp_a_o[i], wb_regwrite && wb_wreg != 0 && wb_wreg == id_rs);
            chk($sformatf("byp_b[%0d]", i), byp_b_o[i], wb_regwrite && wb_wreg != 0 && wb_wreg == id_rt);
            chk($sformatf("stall_cnt[%0d]", i), (i == 0) ? int'(c1_stall) : int'(c3_stall), exp_cnt(m_scnt[i]));
            chk($sformatf("flush_cnt[%0d]", i), (i == 0) ? int'(c1_flush) : int'(c3_flush), exp_cnt(m_fcnt[i]));
            chk($sformatf("fwd_cnt[%0d]", i), (i == 0) ? int'(c1_fwd) : int'(c3_fwd), exp_cnt(m_wcnt[i]));
        end
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                for (int r = 0; r < NREG; r++) avail[i][r] = 0;
                m_scnt[i] = 0; m_fcnt[i] = 0; m_wcnt[i] = 0;
            end else begin
                if (m_stall(i)) m_scnt[i] = sat(m_scnt[i], cmax[i]);
                if (branch_taken) m_fcnt[i] = sat(m_fcnt[i], cmax[i]);
                if (m_fwd(ex_rs) != 0 || m_fwd(ex_rt) != 0) m_wcnt[i] = sat(m_wcnt[i], cmax[i]);
                if (ld_in_ex() && !branch_taken) avail[i][ex_wreg] = cyc + lat[i];
            end
        end
        cyc++;
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic run();
        eval();
        adv();
    endtask

    task automatic set_idle();
        id_valid = 0; id_rs = 0; id_rt = 0; id_use_rs = 0; id_use_rt = 0;
        ex_valid = 0; ex_rs = 0; ex_rt = 0; ex_wreg = 0; ex_regwrite = 0; ex_is_load = 0;
        mem_wreg = 0; mem_regwrite = 0; wb_wreg = 0; wb_regwrite = 0; branch_taken = 0;
    endtask

    task automatic load_in_ex(input logic [4:0] r);
        ex_valid = 1; ex_is_load = 1; ex_regwrite = 1; ex_wreg = r;
    endtask

    task automatic id_dep_rs(input logic [4:0] r);
        id_valid = 1; id_use_rs = 1; id_rs = r;
    endtask

    typedef struct {
        logic idv; logic [4:0] rs; logic [4:0] rt; logic urs; logic urt;
        logic exv; logic [4:0] exrs; logic [4:0] exrt; logic [4:0] exw; logic exrw; logic exld;
        logic [4:0] mw; logic mrw; logic [4:0] ww; logic wrw; logic br;
        logic e_st; logic e_fl; logic e_bu; logic [1:0] e_fa; logic [1:0] e_fb; logic e_ba; logic e_bb;
    } vec_t;

    vec_t vt[15];

    initial begin
        n_pass = 0; n_total = 0; cyc = 0;
        model_clear();
        set_idle();
        rst = 1;
        adv(); adv();

        //        idv rs rt urs urt exv exrs exrt exw exrw exld mw mrw ww wrw br | st fl bu fa fb ba bb
        vt[0]  = '{0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0};
        vt[1]  = '{0, 0, 0, 0, 0,  0, 5, 0, 0, 0, 0,  5, 1, 5, 1, 0,  0, 0, 0, 2, 0, 0, 0};
        vt[2]  = '{0, 0, 0, 0, 0,  0, 5, 0, 0, 0, 0,  5, 0, 5, 1, 0,  0, 0, 0, 1, 0, 0, 0};
        vt[3]  = '{0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0,  0, 1, 0, 1, 0,  0, 0, 0, 0, 0, 0, 0};
        vt[4]  = '{0, 0, 0, 0, 0,  0, 3, 7, 0, 0, 0,  7, 1, 3, 1, 0,  0, 0, 0, 1, 2, 0, 0};
        vt[5]  = '{1, 9, 9, 0, 0,  0, 0, 0, 0, 0, 0,  0, 0, 9, 1, 0,  0, 0, 0, 0, 0, 1, 1};
        vt[6]  = '{1, 0, 0, 1, 1,  0, 0, 0, 0, 0, 0,  0, 0, 0, 1, 0,  0, 0, 0, 0, 0, 0, 0};
        vt[7]  = '{1, 1, 0, 1, 0,  1, 0, 0, 1, 1, 1,  0, 0, 0, 0, 0,  1, 0, 1, 0, 0, 0, 0};
        vt[8]  = '{1, 1, 0, 1, 0,  1, 0, 0, 1, 1, 1,  0, 0, 0, 0, 1,  0, 1, 1, 0, 0, 0, 0};
        vt[9]  = '{1, 0, 0, 1, 0,  1, 0, 0, 0, 1, 1,  0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0};
        vt[10] = '{1, 2, 1, 1, 0,  1, 0, 0, 1, 1, 1,  0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0};
        vt[11] = '{1, 2, 1, 0, 1,  1, 0, 0, 1, 1, 1,  0, 0, 0, 0, 0,  1, 0, 1, 0, 0, 0, 0};
        vt[12] = '{1, 1, 0, 1, 0,  1, 0, 0, 1, 1, 0,  0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0};
        vt[13] = '{0, 1, 0, 1, 0,  1, 0, 0, 1, 1, 1,  0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0};
        vt[14] = '{0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 1,  0, 1, 1, 0, 0, 0, 0};

        // Table vectors run under reset: outputs must still follow inputs, scoreboard stays clear.
        for (int k = 0; k < 15; k++) begin
            id_valid = vt[k].idv; id_rs = vt[k].rs; id_rt = vt[k].rt;
            id_use_rs = vt[k].urs; id_use_rt = vt[k].urt;
            ex_valid = vt[k].exv; ex_rs = vt[k].exrs; ex_rt = vt[k].exrt; ex_wreg = vt[k].exw;
            ex_regwrite = vt[k].exrw; ex_is_load = vt[k].exld;
            mem_wreg = vt[k].mw; mem_regwrite = vt[k].mrw; wb_wreg = vt[k].ww; wb_regwrite = vt[k].wrw;
            branch_taken = vt[k].br;
            eval();
            for (int i = 0; i < 2; i++) begin
                chk($sformatf("vec%0d.stall[%0d]", k, i), stall_o[i], vt[k].e_st);
                chk($sformatf("vec%0d.flush[%0d]", k, i), flush_o[i], vt[k].e_fl);
                chk($sformatf("vec%0d.bubble[%0d]", k, i), bubble_o[i], vt[k].e_bu);
                chk($sformatf("vec%0d.fwd_a[%0d]", k, i), fwd_a_o[i], vt[k].e_fa);
                chk($sformatf("vec%0d.fwd_b[%0d]", k, i), fwd_b_o[i], vt[k].e_fb);
                chk($sformatf("vec%0d.byp_a[%0d]", k, i), byp_a_o[i], vt[k].e_ba);
                chk($sformatf("vec%0d.byp_b[%0d]", k, i), byp_b_o[i], vt[k].e_bb);
            end
            adv();
        end

        // Reset state with idle inputs.
        set_idle();
        rst = 0;
        eval();
        chk("reset.stall_cnt[1]", c3_stall, 0);
        chk("reset.stall_cnt[0]", c1_stall, 0);
        chk("reset.flush_cnt[0]", c1_flush, 0);
        adv();

        // Load-use pair: lw r1 in EX, dependent add in ID.
        load_in_ex(1); id_dep_rs(1);
        eval();
        chk("lu.c1.stall[0]", stall_o[0], 1); chk("lu.c1.stall[1]", stall_o[1], 1);
        chk("lu.c1.bubble[0]", bubble_o[0], 1);
        adv();
        set_idle(); id_dep_rs(1); mem_wreg = 1; mem_regwrite = 1;
        eval();
        chk("lu.c2.stall[0]", stall_o[0], 0); chk("lu.c2.stall[1]", stall_o[1], 1);
        adv();
        set_idle(); id_dep_rs(1);
        eval();
        chk("lu.c3.stall[1]", stall_o[1], 1);
        adv();
        eval();
        chk("lu.c4.stall[1]", stall_o[1], 0);
        adv();
        set_idle(); ex_valid = 1; ex_rs = 1; wb_wreg = 1; wb_regwrite = 1;
        eval();
        chk("lu.wb_fwd_a[0]", fwd_a_o[0], 1);
        chk("lu.stall_cnt[1]", c3_stall, exp_cnt(3));
        chk("lu.stall_cnt[0]", c1_stall, exp_cnt(1));
        adv();

        // Load-use together with a taken branch: flush wins and the load is not tracked.
        set_idle(); rst = 1; run(); rst = 0;
        load_in_ex(4); id_dep_rs(4); branch_taken = 1;
        eval();
        chk("br.stall[1]", stall_o[1], 0); chk("br.flush[1]", flush_o[1], 1); chk("br.bubble[1]", bubble_o[1], 1);
        adv();
        set_idle(); id_dep_rs(4);
        eval();
        chk("br.next.stall[1]", stall_o[1], 0);
        chk("br.flush_cnt[1]", c3_flush, exp_cnt(1));
        chk("br.stall_cnt[1]", c3_stall, exp_cnt(0));
        adv();

        // Reset in the middle of a scoreboard stall.
        set_idle(); load_in_ex(3); id_dep_rs(3);
        run();
        set_idle(); id_dep_rs(3); rst = 1;
        eval();
        chk("rst_mid.during.stall[1]", stall_o[1], 1);
        adv();
        rst = 0;
        eval();
        chk("rst_mid.after.stall[1]", stall_o[1], 0);
        adv();

        // Counter saturation: 20 consecutive stall cycles.
        set_idle(); rst = 1; run(); rst = 0;
        load_in_ex(2); id_dep_rs(2);
        for (int n = 0; n < 20; n++) run();
        set_idle();
        eval();
        chk("sat.stall_cnt[1]", c3_stall, exp_cnt(15));
        chk("sat.stall_cnt[0]", c1_stall, exp_cnt(20));
        adv();
        rst = 1; run(); rst = 0;
        eval();
        chk("sat.rst.stall_cnt[1]", c3_stall, 0);
        adv();

        // Random traffic against the model.
        for (int n = 0; n < 400; n++) begin
            rst = ($urandom_range(0, 49) == 0);
            id_valid = $urandom_range(0, 1); id_rs = 5'($urandom_range(0, 3)); id_rt = 5'($urandom_range(0, 3));
            id_use_rs = $urandom_range(0, 1); id_use_rt = $urandom_range(0, 1);
            ex_valid = $urandom_range(0, 1); ex_rs = 5'($urandom_range(0, 3)); ex_rt = 5'($urandom_range(0, 3));
            ex_wreg = 5'($urandom_range(0, 3)); ex_regwrite = $urandom_range(0, 1); ex_is_load = $urandom_range(0, 1);
            mem_wreg = 5'($urandom_range(0, 3)); mem_regwrite = $urandom_range(0, 1);
            wb_wreg = 5'($urandom_range(0, 3)); wb_regwrite = $urandom_range(0, 1);
            branch_taken = ($urandom_range(0, 7) == 0);
            run();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/pipe_hazard_unit.md
PIPE_HAZARD_UNIT -- requirements
Module: pipe_hazard_unit

Interface
REQ-001 SHALL have parameter NREG, default 32: architectural register count; REGW = $clog2(NREG) is derived.
REQ-002 SHALL have parameter MEM_LAT, default 1: data-memory load latency in cycles, legal 1..4.
REQ-003 SHALL have parameter CNT_W, default 16: performance-counter width.
REQ-004 SHALL use one clock; reset is synchronous and active-high; ports: clk  in  1  clock; rst  in  1  synchronous active-high reset.
REQ-005 SHALL have ID inputs: id_valid 1, id_rs REGW, id_rt REGW, id_use_rs 1, id_use_rt 1 (source actually read).
REQ-006 SHALL have EX inputs: ex_valid 1, ex_rs REGW, ex_rt REGW, ex_wreg REGW, ex_regwrite 1, ex_is_load 1.
REQ-007 SHALL have MEM/WB inputs: mem_wreg REGW, mem_regwrite 1, wb_wreg REGW, wb_regwrite 1.
REQ-008 SHALL have branch_taken  in  1  redirect resolved in EX.
REQ-009 SHALL have outputs: stall 1 (hold PC and IF/ID); flush_ifid 1; bubble_idex 1 (zero ID/EX controls); fwd_a 2, fwd_b 2 (EX operand select); id_byp_a 1, id_byp_b 1 (WB-to-ID bypass).
REQ-010 SHALL have outputs stall_cnt, flush_cnt, fwd_cnt, each CNT_W wide.

Function
REQ-011 fwd_a/fwd_b encoding SHALL be 00 ID/EX register value, 10 EX/MEM result, 01 MEM/WB write data; 11 never driven.
REQ-012 fwd_a SHALL be 10 when mem_regwrite, mem_wreg!=0, mem_wreg==ex_rs; else 01 when wb_regwrite, wb_wreg!=0, wb_wreg==ex_rs; else 00. EX/MEM has priority. fwd_b is identical using ex_rt.
REQ-013 id_byp_a SHALL be 1 when wb_regwrite, wb_wreg!=0, wb_wreg==id_rs; id_byp_b likewise for id_rt.
REQ-014 A source is hazard-checked only when id_valid and its id_use_* bit are set and the register is nonzero.
REQ-015 Scoreboard: per-register 3-bit countdown sb[r], r=1..NREG-1; sb[0] is constant 0.
REQ-016 Load issue: at a clock edge with ex_valid, ex_is_load, ex_regwrite, ex_wreg!=0 and branch_taken=0, sb[ex_wreg] SHALL load MEM_LAT-1.
REQ-017 Every other nonzero sb[r] SHALL decrement by 1 per cycle; a same-cycle load issue overrides the decrement.
REQ-018 stall SHALL be a combinational 1 when a checked source equals ex_wreg of a qualifying EX load (REQ-016 conditions) or has sb!=0; no added latency.
REQ-019 With MEM_LAT=1, a load-use pair SHALL stall exactly 1 cycle; in general exactly MEM_LAT cycles.
REQ-020 bubble_idex SHALL equal stall OR branch_taken; flush_ifid SHALL equal branch_taken.
REQ-021 branch_taken SHALL force stall=0 (flush wins over stall in the same cycle).
REQ-022 Flush SHALL NOT clear scoreboard entries; loads already past EX still complete.
REQ-023 stall_cnt +1 per cycle with stall=1; flush_cnt +1 per cycle with branch_taken=1; fwd_cnt +1 per cycle with fwd_a!=00 or fwd_b!=00. All saturate at all-ones, no wrap.

Reset
REQ-024 rst SHALL clear all sb entries and all counters at the next clock edge.
REQ-025 Combinational outputs SHALL follow inputs during reset; with inputs idle (all valids 0) every output SHALL be 0.
REQ-026 Reset asserted mid-stall SHALL leave no scoreboard-induced stall in the first cycle after reset deasserts.

Configuration
REQ-027 Macro PIPE_HAZARD_PERF_CNT_EN defined: counters implemented per REQ-023; undefined: no counter flops, stall_cnt/flush_cnt/fwd_cnt tied 0, all other behaviour unchanged.

Verification
REQ-028 MEM_LAT=1: lw r1 in EX, add r2,r1,r3 in ID (use_rs=1) -> stall=1, bubble_idex=1 for 1 cycle, then fwd_a=01 in EX.
REQ-029 MEM_LAT=3: same pair -> stall for exactly 3 consecutive cycles; stall_cnt=3 afterwards.
REQ-030 mem_wreg=wb_wreg=5, both regwrite, ex_rs=5 -> fwd_a=10; with mem_regwrite=0 -> fwd_a=01; wreg=0 -> fwd_a=00.
REQ-031 Load-use hazard plus branch_taken in the same cycle -> stall=0, flush_ifid=1, bubble_idex=1, flush_cnt +1.
REQ-032 lw into r0, dependent on r0 -> no stall; id_use_rt=0 with id_rt matching the load -> no stall.
REQ-033 CNT_W=4, 20 stall cycles -> stall_cnt=15; rst -> 0; with macro undefined -> always 0.
